// File: rtl/vi_mem_pkg.sv
// Shared types for the cache-to-memory arbiter.
// States, grant encoding and line-offset helper.
package vi_mem_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [2:0] {
        IDLE,
        I_FILL,
        D_WB,
        D_GAP,
        D_FILL,
        RESP
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D
    } grant_t;

    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Data-priority grant with an icache starvation guard.
// The counter only moves when a grant is actually issued.
module mem_arb_prio
    import vi_mem_pkg::*;
#(
    parameter int STARVE_MAX = 2
) (
    input  logic   clk_i,
    input  logic   rsn_i,
    input  logic   en,
    input  logic   ic_rqst,
    input  logic   dc_rqst,
    output grant_t grant
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    always_comb begin
        grant = GRANT_NONE;
        if (en) begin
            if (ic_rqst && dc_rqst) begin
                grant = (starve_cnt == CNT_MAX) ? GRANT_I : GRANT_D;
            end else if (dc_rqst) begin
                grant = GRANT_D;
            end else if (ic_rqst) begin
                grant = GRANT_I;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_I) begin
            starve_cnt <= '0;
        end else if (grant == GRANT_D && ic_rqst && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache fills and dcache writeback+fill onto one memory port.
// All outputs are registered; addresses leave line-aligned.
module mem_arbiter
    import vi_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_W     = LINE_W_DEF,
    parameter int STARVE_MAX = 2
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_rqst_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_data_ready_o,
    output logic [LINE_W-1:0] ic_data_o,
    output logic [ADDR_W-1:0] ic_addr_o,
    input  logic              dc_rqst_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic              dc_wb_i,
    input  logic [ADDR_W-1:0] dc_wb_addr_i,
    input  logic [LINE_W-1:0] dc_wb_data_i,
    output logic              dc_data_ready_o,
    output logic [LINE_W-1:0] dc_data_o,
    output logic [ADDR_W-1:0] dc_addr_o,
    output logic              mem_rqst_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              busy_o
);

    localparam int OFF = off_w(LINE_W);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);

    mem_arb_state_t state, state_next;
    grant_t grant;

    logic [ADDR_W-1:0] fill_addr, fill_addr_n;
    logic [ADDR_W-1:0] addr_n;
    logic [LINE_W-1:0] wdata_n;
    logic rqst_n, we_n, ack, ic_load, dc_load;

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk_i  (clk_i),
        .rsn_i  (rsn_i),
        .en     (state == IDLE),
        .ic_rqst(ic_rqst_i),
        .dc_rqst(dc_rqst_i),
        .grant  (grant)
    );

    // Acks only count while a request is actually outstanding.
    assign ack = mem_rqst_o && mem_ack_i;

    always_comb begin
        state_next  = state;
        rqst_n      = mem_rqst_o;
        we_n        = mem_we_o;
        addr_n      = mem_addr_o;
        wdata_n     = mem_data_o;
        fill_addr_n = fill_addr;
        ic_load     = 1'b0;
        dc_load     = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (grant)
                    GRANT_I: begin
                        state_next = I_FILL;
                        rqst_n     = 1'b1;
                        we_n       = 1'b0;
                        addr_n     = ic_addr_i & ~OFF_MASK;
                    end
                    GRANT_D: begin
                        rqst_n      = 1'b1;
                        fill_addr_n = dc_addr_i & ~OFF_MASK;
                        if (dc_wb_i) begin
                            state_next = D_WB;
                            we_n       = 1'b1;
                            addr_n     = dc_wb_addr_i & ~OFF_MASK;
                            wdata_n    = dc_wb_data_i;
                        end else begin
                            state_next = D_FILL;
                            we_n       = 1'b0;
                            addr_n     = dc_addr_i & ~OFF_MASK;
                        end
                    end
                    default: ;
                endcase
            end
            I_FILL: begin
                if (ack) begin
                    state_next = RESP;
                    rqst_n     = 1'b0;
                    ic_load    = 1'b1;
                end
            end
            D_WB: begin
                if (ack) begin
                    state_next = D_GAP;
                    rqst_n     = 1'b0;
                end
            end
            D_GAP: begin
                state_next = D_FILL;
                rqst_n     = 1'b1;
                we_n       = 1'b0;
                addr_n     = fill_addr;
            end
            D_FILL: begin
                if (ack) begin
                    state_next = RESP;
                    rqst_n     = 1'b0;
                    dc_load    = 1'b1;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state           <= IDLE;
            fill_addr       <= '0;
            mem_rqst_o      <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_data_o      <= '0;
            ic_data_ready_o <= 1'b0;
            ic_data_o       <= '0;
            ic_addr_o       <= '0;
            dc_data_ready_o <= 1'b0;
            dc_data_o       <= '0;
            dc_addr_o       <= '0;
            busy_o          <= 1'b0;
        end else begin
            state           <= state_next;
            fill_addr       <= fill_addr_n;
            mem_rqst_o      <= rqst_n;
            mem_we_o        <= we_n;
            mem_addr_o      <= addr_n;
            mem_data_o      <= wdata_n;
            ic_data_ready_o <= ic_load;
            dc_data_ready_o <= dc_load;
            busy_o          <= (state_next != IDLE);
            if (ic_load) begin
                ic_data_o <= mem_data_i;
                ic_addr_o <= mem_addr_o;
            end
            if (dc_load) begin
                dc_data_o <= mem_data_i;
                dc_addr_o <= mem_addr_o;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fills, writeback, starvation,
// stray acks, async reset and zero-wait latency.
module tb_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b0;
    logic         ic_rqst_i = 1'b0;
    logic [19:0]  ic_addr_i = '0;
    logic         ic_data_ready_o;
    logic [127:0] ic_data_o;
    logic [19:0]  ic_addr_o;
    logic         dc_rqst_i = 1'b0;
    logic [19:0]  dc_addr_i = '0;
    logic         dc_wb_i = 1'b0;
    logic [19:0]  dc_wb_addr_i = '0;
    logic [127:0] dc_wb_data_i = '0;
    logic         dc_data_ready_o;
    logic [127:0] dc_data_o;
    logic [19:0]  dc_addr_o;
    logic         mem_rqst_o;
    logic         mem_we_o;
    logic [19:0]  mem_addr_o;
    logic [127:0] mem_data_o;
    logic         mem_ack_i = 1'b0;
    logic [127:0] mem_data_i = '0;
    logic         busy_o;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PAT_A5 = {4{32'hA5A5A5A5}};
    localparam logic [127:0] PAT_11 = {4{32'h11111111}};
    localparam logic [127:0] PAT_CF = {4{32'hCAFEF00D}};
    localparam logic [127:0] PAT_5A = {4{32'h5A5A5A5A}};
    localparam logic [127:0] PAT_77 = {4{32'h77777777}};

    mem_arbiter dut (
        .clk_i          (clk_i),
        .rsn_i          (rsn_i),
        .ic_rqst_i      (ic_rqst_i),
        .ic_addr_i      (ic_addr_i),
        .ic_data_ready_o(ic_data_ready_o),
        .ic_data_o      (ic_data_o),
        .ic_addr_o      (ic_addr_o),
        .dc_rqst_i      (dc_rqst_i),
        .dc_addr_i      (dc_addr_i),
        .dc_wb_i        (dc_wb_i),
        .dc_wb_addr_i   (dc_wb_addr_i),
        .dc_wb_data_i   (dc_wb_data_i),
        .dc_data_ready_o(dc_data_ready_o),
        .dc_data_o      (dc_data_o),
        .dc_addr_o      (dc_addr_o),
        .mem_rqst_o     (mem_rqst_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_ack_i      (mem_ack_i),
        .mem_data_i     (mem_data_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a request, checks its address, acks it at once.
    task automatic serve(input string tag, input logic [19:0] exp_addr,
                         input logic exp_i, input logic [127:0] d);
        int n = 0;
        while (!mem_rqst_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " rqst"}, {127'b0, mem_rqst_o}, 128'd1);
        chk({tag, " addr"}, {108'b0, mem_addr_o}, {108'b0, exp_addr});
        mem_ack_i  = 1'b1;
        mem_data_i = d;
        tick();
        mem_ack_i = 1'b0;
        chk({tag, " ic_rdy"}, {127'b0, ic_data_ready_o}, {127'b0, exp_i});
        chk({tag, " dc_rdy"}, {127'b0, dc_data_ready_o}, {127'b0, !exp_i});
        chk({tag, " data"}, exp_i ? ic_data_o : dc_data_o, d);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst rqst", {127'b0, mem_rqst_o}, 128'd0);
        chk("rst busy", {127'b0, busy_o}, 128'd0);
        chk("rst maddr", {108'b0, mem_addr_o}, 128'd0);
        chk("rst icdata", ic_data_o, 128'd0);
        chk("rst dcdata", dc_data_o, 128'd0);
        rsn_i = 1'b1;
        tick();

        // icache fill, ack three cycles after request rises
        ic_rqst_i = 1'b1;
        ic_addr_i = 20'h12345;
        tick();
        chk("t1 rqst", {127'b0, mem_rqst_o}, 128'd1);
        chk("t1 maddr", {108'b0, mem_addr_o}, 128'h12340);
        chk("t1 we", {127'b0, mem_we_o}, 128'd0);
        chk("t1 busy", {127'b0, busy_o}, 128'd1);
        tick();
        tick();
        chk("t1 hold", {127'b0, mem_rqst_o}, 128'd1);
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = PAT_A5;
        tick();
        mem_ack_i = 1'b0;
        chk("t1 rdy", {127'b0, ic_data_ready_o}, 128'd1);
        chk("t1 data", ic_data_o, PAT_A5);
        chk("t1 iaddr", {108'b0, ic_addr_o}, 128'h12340);
        chk("t1 rqst low", {127'b0, mem_rqst_o}, 128'd0);
        chk("t1 dcrdy", {127'b0, dc_data_ready_o}, 128'd0);
        chk("t1 dcdata", dc_data_o, 128'd0);
        ic_rqst_i = 1'b0;
        tick();
        chk("t1 pulse", {127'b0, ic_data_ready_o}, 128'd0);
        chk("t1 idle", {127'b0, busy_o}, 128'd0);

        // dcache writeback then fill
        dc_rqst_i    = 1'b1;
        dc_wb_i      = 1'b1;
        dc_wb_addr_i = 20'h00F10;
        dc_wb_data_i = PAT_11;
        dc_addr_i    = 20'h00A04;
        tick();
        dc_wb_data_i = '0;
        dc_addr_i    = 20'hFFFFF;
        chk("t2 wb rqst", {127'b0, mem_rqst_o}, 128'd1);
        chk("t2 wb we", {127'b0, mem_we_o}, 128'd1);
        chk("t2 wb addr", {108'b0, mem_addr_o}, 128'h00F10);
        chk("t2 wb data", mem_data_o, PAT_11);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk("t2 gap", {127'b0, mem_rqst_o}, 128'd0);
        chk("t2 gap rdy", {127'b0, dc_data_ready_o}, 128'd0);
        tick();
        chk("t2 rd rqst", {127'b0, mem_rqst_o}, 128'd1);
        chk("t2 rd we", {127'b0, mem_we_o}, 128'd0);
        chk("t2 rd addr", {108'b0, mem_addr_o}, 128'h00A00);
        mem_ack_i  = 1'b1;
        mem_data_i = PAT_CF;
        tick();
        mem_ack_i = 1'b0;
        chk("t2 rdy", {127'b0, dc_data_ready_o}, 128'd1);
        chk("t2 data", dc_data_o, PAT_CF);
        chk("t2 daddr", {108'b0, dc_addr_o}, 128'h00A00);
        chk("t2 icrdy", {127'b0, ic_data_ready_o}, 128'd0);
        dc_rqst_i = 1'b0;
        dc_wb_i   = 1'b0;
        tick();
        chk("t2 pulse", {127'b0, dc_data_ready_o}, 128'd0);
        chk("t2 ichold", ic_data_o, PAT_A5);

        // stray ack while idle
        mem_ack_i  = 1'b1;
        mem_data_i = {128{1'b1}};
        tick();
        mem_ack_i = 1'b0;
        chk("t4 busy", {127'b0, busy_o}, 128'd0);
        chk("t4 rqst", {127'b0, mem_rqst_o}, 128'd0);
        chk("t4 icrdy", {127'b0, ic_data_ready_o}, 128'd0);
        chk("t4 dcrdy", {127'b0, dc_data_ready_o}, 128'd0);
        chk("t4 dchold", dc_data_o, PAT_CF);

        // both requesting: D, D, I, D, D, I
        ic_rqst_i = 1'b1;
        ic_addr_i = 20'h00100;
        dc_rqst_i = 1'b1;
        dc_addr_i = 20'h00200;
        serve("s1 D", 20'h00200, 1'b0, 128'h1);
        serve("s2 D", 20'h00200, 1'b0, 128'h2);
        serve("s3 I", 20'h00100, 1'b1, 128'h3);
        serve("s4 D", 20'h00200, 1'b0, 128'h4);
        serve("s5 D", 20'h00200, 1'b0, 128'h5);
        serve("s6 I", 20'h00100, 1'b1, 128'h6);
        ic_rqst_i = 1'b0;
        dc_rqst_i = 1'b0;
        tick();
        chk("s idle", {127'b0, busy_o}, 128'd0);

        // async reset during a dcache fill
        dc_rqst_i = 1'b1;
        dc_addr_i = 20'h00333;
        tick();
        chk("t5 fill", {127'b0, mem_rqst_o}, 128'd1);
        #3;
        rsn_i = 1'b0;
        #1;
        chk("t5 rqst", {127'b0, mem_rqst_o}, 128'd0);
        chk("t5 busy", {127'b0, busy_o}, 128'd0);
        chk("t5 maddr", {108'b0, mem_addr_o}, 128'd0);
        chk("t5 icdata", ic_data_o, 128'd0);
        chk("t5 dcdata", dc_data_o, 128'd0);
        dc_rqst_i = 1'b0;
        tick();
        tick();
        rsn_i = 1'b1;
        ic_rqst_i = 1'b1;
        ic_addr_i = 20'h0044F;
        tick();
        chk("t5 ic rqst", {127'b0, mem_rqst_o}, 128'd1);
        chk("t5 ic addr", {108'b0, mem_addr_o}, 128'h00440);
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = PAT_77;
        tick();
        mem_ack_i = 1'b0;
        chk("t5 ic rdy", {127'b0, ic_data_ready_o}, 128'd1);
        chk("t5 ic data", ic_data_o, PAT_77);
        ic_rqst_i = 1'b0;
        tick();

        // zero-wait memory: grant, ack, ready, idle
        ic_rqst_i = 1'b1;
        ic_addr_i = 20'h0ABCD;
        tick();
        chk("t6 rqst", {127'b0, mem_rqst_o}, 128'd1);
        mem_ack_i  = 1'b1;
        mem_data_i = PAT_5A;
        tick();
        mem_ack_i = 1'b0;
        chk("t6 rdy", {127'b0, ic_data_ready_o}, 128'd1);
        chk("t6 data", ic_data_o, PAT_5A);
        chk("t6 iaddr", {108'b0, ic_addr_o}, 128'h0ABC0);
        chk("t6 busy", {127'b0, busy_o}, 128'd1);
        ic_rqst_i = 1'b0;
        tick();
        chk("t6 idle", {127'b0, busy_o}, 128'd0);
        chk("t6 pulse", {127'b0, ic_data_ready_o}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
